// File: rtl/voice_mix_scheduler_if.sv
// Handshake bundle for the mix scheduler: voice requests to the shared
// wave-generator datapath and the mixed-sample stream to the I2S stage.
interface voice_mix_scheduler_if #(
    parameter int N_VOICES = 8,
    parameter int SAMPLE_W = 24
);
    localparam int IDX_W = $clog2(N_VOICES);

    logic                voice_req;
    logic [IDX_W-1:0]    voice_idx;
    logic                voice_ack;
    logic [SAMPLE_W-1:0] voice_sample;
    logic [SAMPLE_W-1:0] out_sample;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output voice_req, voice_idx, out_sample, out_valid,
        input  voice_ack, voice_sample, out_ready
    );

    modport slave (
        input  voice_req, voice_idx, out_sample, out_valid,
        output voice_ack, voice_sample, out_ready
    );
endinterface

// File: rtl/voice_mix_scheduler.sv
// Per-sample voice mixer: walks all voice slots, sums, applies master volume.
// Define MIX_SATURATE_EN to clamp both reductions instead of wrapping.
//
// state | meaning
// IDLE  | waiting for sample_tick
// RUN   | visiting voice slot idx (request or skip)
// SCALE | reduce, apply volume, register out_sample
// OUT   | presenting out_sample until out_ready
module voice_mix_scheduler #(
    parameter int N_VOICES = 8,
    parameter int SAMPLE_W = 24
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sample_tick,
    input  logic [N_VOICES-1:0]   voice_active,
    input  logic [15:0]           volume,
    voice_mix_scheduler_if.master bus,
    output logic                  busy,
    output logic [7:0]            overrun_cnt
);
    localparam int IDX_W  = $clog2(N_VOICES);
    localparam int ACC_W  = SAMPLE_W + IDX_W;
    localparam int PROD_W = SAMPLE_W + 17;
    localparam logic [SAMPLE_W-1:0] SMAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] SMIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, SCALE, OUT} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [N_VOICES-1:0]   mask_q, mask_d;
    logic [15:0]           vol_q, vol_d;
    logic [SAMPLE_W-1:0]   out_q, out_d;
    logic [7:0]            ovr_q, ovr_d;

    logic signed [SAMPLE_W-1:0] reduced;
    logic signed [SAMPLE_W-1:0] scaled;
    logic signed [PROD_W-1:0]   product;
    logic                       unused_prod;

    assign bus.voice_req  = (state_q == RUN) && mask_q[idx_q];
    assign bus.voice_idx  = idx_q;
    assign bus.out_valid  = (state_q == OUT);
    assign bus.out_sample = out_q;
    assign busy           = (state_q != IDLE);
    assign overrun_cnt    = ovr_q;
    assign unused_prod    = ^{product[PROD_W-1:SAMPLE_W+15], product[14:0]};

    // Volume is zero-extended so 0x8000..0xFFFF stay positive gains.
    always_comb begin
        reduced = acc_q[SAMPLE_W-1:0];
`ifdef MIX_SATURATE_EN
        if (acc_q[ACC_W-1:SAMPLE_W-1] != {(IDX_W+1){acc_q[ACC_W-1]}})
            reduced = acc_q[ACC_W-1] ? SMIN : SMAX;
`endif
        product = $signed({{(PROD_W-SAMPLE_W){reduced[SAMPLE_W-1]}}, reduced})
                * $signed({{(PROD_W-16){1'b0}}, vol_q});
        scaled = product[SAMPLE_W+14:15];
`ifdef MIX_SATURATE_EN
        if (product[PROD_W-1:SAMPLE_W+14] != {3{product[PROD_W-1]}})
            scaled = product[PROD_W-1] ? SMIN : SMAX;
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        mask_d  = mask_q;
        vol_d   = vol_q;
        out_d   = out_q;
        ovr_d   = ovr_q;

        if (sample_tick && (state_q != IDLE) && (ovr_q != 8'hFF))
            ovr_d = ovr_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    mask_d  = voice_active;
                    vol_d   = volume;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!mask_q[idx_q] || bus.voice_ack) begin
                    if (mask_q[idx_q])
                        acc_d = acc_q + $signed({{IDX_W{bus.voice_sample[SAMPLE_W-1]}},
                                                 bus.voice_sample});
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(N_VOICES-1))
                        state_d = SCALE;
                end
            end
            SCALE: begin
                out_d   = scaled;
                state_d = OUT;
            end
            OUT: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            mask_q  <= '0;
            vol_q   <= '0;
            out_q   <= '0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            mask_q  <= mask_d;
            vol_q   <= vol_d;
            out_q   <= out_d;
            ovr_q   <= ovr_d;
        end
    end
endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Scoreboard bench for voice_mix_scheduler with N_VOICES=4, SAMPLE_W=24.
module tb_voice_mix_scheduler;
    localparam int NV = 4;
    localparam int SW = 24;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          sample_tick = 1'b0;
    logic [NV-1:0] voice_active = '0;
    logic [15:0]   volume = '0;
    logic          busy;
    logic [7:0]    overrun_cnt;
    logic [SW-1:0] samp [NV];
    logic [NV-1:0] ack_en = '1;

    voice_mix_scheduler_if #(.N_VOICES(NV), .SAMPLE_W(SW)) bus();

    voice_mix_scheduler #(.N_VOICES(NV), .SAMPLE_W(SW)) dut (
        .clk(clk),
        .rstn(rstn),
        .sample_tick(sample_tick),
        .voice_active(voice_active),
        .volume(volume),
        .bus(bus),
        .busy(busy),
        .overrun_cnt(overrun_cnt)
    );

    assign bus.voice_ack    = bus.voice_req & ack_en[bus.voice_idx];
    assign bus.voice_sample = samp[bus.voice_idx];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string         nm;
        logic [SW-1:0] s;
        int            vcyc;
    } exp_t;

    exp_t          sbq[$];
    int            errors = 0;
    int            checks = 0;
    logic          prev_valid = 1'b0;
    logic [NV-1:0] req_seen = '0;
    int            first_idx = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on every out handshake, latency checked on valid rise.
    always @(negedge clk) begin
        if (bus.voice_req) begin
            if (req_seen == '0) first_idx = int'(bus.voice_idx);
            req_seen[bus.voice_idx] = 1'b1;
        end
        if (bus.out_valid && !prev_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL valid_unexpected: out_valid at cycle %0d with empty scoreboard", cyc);
            end else if (cyc != sbq[0].vcyc) begin
                errors++;
                $display("FAIL %s_latency: valid at cycle %0d expected %0d", sbq[0].nm, cyc, sbq[0].vcyc);
            end
        end
        if (bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: sample 0x%0h with empty scoreboard", bus.out_sample);
            end else begin
                check(sbq[0].nm, 32'(bus.out_sample), 32'(sbq[0].s));
                void'(sbq.pop_front());
            end
        end
        prev_valid = bus.out_valid;
    end

    task automatic frame(input string nm, input logic [NV-1:0] m, input logic [15:0] v,
                         input bit push, input logic [SW-1:0] e);
        @(posedge clk); #1;
        voice_active = m;
        volume       = v;
        sample_tick  = 1'b1;
        req_seen     = '0;
        first_idx    = -1;
        if (push) sbq.push_back('{nm, e, cyc + 6});
        @(posedge clk); #1;
        sample_tick = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: busy still 1 after 200 cycles", nm);
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.out_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: out_valid not seen after 200 cycles", nm);
    endtask

    task automatic set_samples(input logic [SW-1:0] a, input logic [SW-1:0] b,
                               input logic [SW-1:0] c, input logic [SW-1:0] d);
        samp[0] = a; samp[1] = b; samp[2] = c; samp[3] = d;
    endtask

    logic [SW-1:0] sat_exp;
    bit            hit;

    initial begin
        bus.out_ready = 1'b1;
        set_samples(24'h000100, 24'h000200, 24'h000300, 24'h000400);
`ifdef MIX_SATURATE_EN
        sat_exp = 24'h7FFFFF;
`else
        sat_exp = 24'hFFFFFC;
`endif

        #2 rstn = 1'b0;
        #1;
        check("rst_voice_req", 32'(bus.voice_req), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun_cnt), 32'd0);
        check("rst_out_sample", 32'(bus.out_sample), 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        frame("basic_mix", 4'b1111, 16'h8000, 1'b1, 24'h000A00);
        wait_idle("basic_mix");

        set_samples(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);
        frame("saturation", 4'b1111, 16'h8000, 1'b1, sat_exp);
        wait_idle("saturation");

        set_samples(24'h000100, 24'h000200, 24'h000300, 24'h000400);
        frame("masking", 4'b0101, 16'h8000, 1'b1, 24'h000400);
        wait_idle("masking");
        check("masking_req_set", 32'(req_seen), 32'h5);

        // Mid-frame changes to mask/volume must not affect the running frame.
        frame("volume_pos", 4'b1111, 16'h4000, 1'b1, 24'h000500);
        voice_active = 4'b0000;
        volume       = 16'hFFFF;
        wait_idle("volume_pos");

        set_samples(24'hFFFF00, 24'hFFFE00, 24'hFFFD00, 24'hFFFC00);
        frame("volume_neg", 4'b1111, 16'h4000, 1'b1, 24'hFFFB00);
        wait_idle("volume_neg");

        set_samples(24'h000100, 24'h000200, 24'h000300, 24'h000400);
        bus.out_ready = 1'b0;
        frame("overrun_frame", 4'b1111, 16'h8000, 1'b1, 24'h000A00);
        wait_valid("overrun_frame");
        req_seen = '0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1 sample_tick = 1'b1;
            @(posedge clk); #1 sample_tick = 1'b0;
        end
        @(negedge clk);
        check("overrun_cnt_2", 32'(overrun_cnt), 32'd2);
        check("overrun_hold_sample", 32'(bus.out_sample), 32'h000A00);
        check("overrun_no_req", 32'(req_seen), 32'd0);
        check("overrun_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        sample_tick   = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        @(negedge clk);
        check("handshake_tick_dropped", 32'(overrun_cnt), 32'd3);
        check("handshake_idle", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        check("no_frame_after_drop", 32'(busy), 32'd0);

        set_samples(24'h000010, 24'h000020, 24'h000030, 24'h000040);
        ack_en = 4'b1011;
        frame("stalled", 4'b1111, 16'h8000, 1'b0, 24'h0);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            if (bus.voice_req && bus.voice_idx == 2'd2) hit = 1'b1;
        end
        check("stall_reached_idx2", 32'(hit), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("midrst_voice_req", 32'(bus.voice_req), 32'd0);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_overrun", 32'(overrun_cnt), 32'd0);
        ack_en = 4'b1111;
        @(posedge clk); #1 rstn = 1'b1;

        frame("post_reset", 4'b1111, 16'h8000, 1'b1, 24'h0000A0);
        wait_idle("post_reset");
        check("post_reset_first_idx", 32'(first_idx), 32'd0);
        check("post_reset_req_set", 32'(req_seen), 32'hF);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
